// File: rtl/fft_bin_streamer.sv
`timescale 1ns/1ps
// Captures one packed FFT frame and streams its bins one per valid/ready handshake.
// Latency: first bin valid one cycle after the accepting frame_strobe.
// Backpressure: bin_ready low holds the current bin stable; strobes arriving mid-frame are dropped and counted.
module fft_bin_streamer #(
    parameter int sample_size = 32,
    parameter int buffer_size = 32
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               frame_strobe,
    input  logic [sample_size*buffer_size-1:0] frame_bitstream,
    input  logic                               flush,
    output logic                               bin_valid,
    input  logic                               bin_ready,
    output logic [sample_size-1:0]             bin_data,
    output logic [$clog2(buffer_size)-1:0]     bin_index,
    output logic                               bin_last,
    output logic                               busy,
    output logic [7:0]                         drop_count
);

    localparam int IW = $clog2(buffer_size);
    localparam logic [IW-1:0] LAST_IDX = IW'(buffer_size - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                         state;
    logic [IW-1:0]                  index;
    logic [sample_size*buffer_size-1:0] frame;

    logic          hs;
    logic          at_last;
    logic [IW-1:0] index_nxt;

    assign hs        = bin_valid & bin_ready;
    assign at_last   = (index == LAST_IDX);
    assign index_nxt = index + 1'b1;

    assign bin_index = index;
    assign bin_data  = frame[32'(index) * sample_size +: sample_size];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            index      <= '0;
            frame      <= '0;
            drop_count <= '0;
            bin_valid  <= 1'b0;
            bin_last   <= 1'b0;
            busy       <= 1'b0;
        end else if (flush) begin
            // Flush wins over any handshake or strobe in the same cycle.
            state     <= IDLE;
            index     <= '0;
            bin_valid <= 1'b0;
            bin_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_strobe) begin
                        frame     <= frame_bitstream;
                        index     <= '0;
                        state     <= STREAM;
                        bin_valid <= 1'b1;
                        bin_last  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                STREAM: begin
                    if (hs && at_last) begin
                        index    <= '0;
                        bin_last <= 1'b0;
                        // A strobe on the final handshake chains the next frame with no bubble.
                        if (frame_strobe) begin
                            frame <= frame_bitstream;
                        end else begin
                            state     <= IDLE;
                            bin_valid <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end else begin
                        if (hs) begin
                            index    <= index_nxt;
                            bin_last <= (index_nxt == LAST_IDX);
                        end
                        if (frame_strobe && drop_count != 8'hff) begin
                            drop_count <= drop_count + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_bin_streamer.sv
`timescale 1ns/1ps
// Directed bench for fft_bin_streamer: stimulus pushes expected bins into a queue, a monitor pops on each handshake.
module tb_fft_bin_streamer;

    localparam int SS = 32;
    localparam int BS = 32;
    localparam int IW = 5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              frame_strobe;
    logic [SS*BS-1:0]  frame_bitstream;
    logic              flush;
    logic              bin_valid;
    logic              bin_ready;
    logic [SS-1:0]     bin_data;
    logic [IW-1:0]     bin_index;
    logic              bin_last;
    logic              busy;
    logic [7:0]        drop_count;

    always #5 clk = ~clk;

    fft_bin_streamer #(.sample_size(SS), .buffer_size(BS)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .frame_strobe    (frame_strobe),
        .frame_bitstream (frame_bitstream),
        .flush           (flush),
        .bin_valid       (bin_valid),
        .bin_ready       (bin_ready),
        .bin_data        (bin_data),
        .bin_index       (bin_index),
        .bin_last        (bin_last),
        .busy            (busy),
        .drop_count      (drop_count)
    );

    typedef struct packed {
        logic [SS-1:0] d;
        logic [IW-1:0] i;
        logic          l;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // mode 0: 10*k-100, mode 1: all -1, mode 2: 1000*k+7
    function automatic logic [SS-1:0] binval(input int mode, input int k);
        case (mode)
            0:       return SS'(10 * k - 100);
            1:       return '1;
            default: return SS'(1000 * k + 7);
        endcase
    endfunction

    function automatic logic [SS*BS-1:0] mkframe(input int mode);
        logic [SS*BS-1:0] f;
        f = '0;
        for (int k = 0; k < BS; k++) f[k*SS +: SS] = binval(mode, k);
        return f;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int mode, input int first, input int last);
        exp_t e;
        for (int k = first; k <= last; k++) begin
            e.d = binval(mode, k);
            e.i = IW'(k);
            e.l = (k == BS - 1);
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, 64'(busy), 64'd0);
        check({name, "_drain"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_index(input int idx);
        int n;
        n = 0;
        while (bin_index != IW'(idx) && n < 100) begin
            tick();
            n++;
        end
        check("wait_index", 64'(bin_index), 64'(idx));
    endtask

    task automatic check_zero(input string name);
        check({name, "_valid"}, 64'(bin_valid), 64'd0);
        check({name, "_busy"},  64'(busy),      64'd0);
        check({name, "_last"},  64'(bin_last),  64'd0);
        check({name, "_index"}, 64'(bin_index), 64'd0);
        check({name, "_data"},  64'(bin_data),  64'd0);
        check({name, "_drop"},  64'(drop_count), 64'd0);
    endtask

    // Monitor: every accepted bin must match the head of the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && bin_valid && bin_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got idx %0d data %0h want no bin", bin_index, bin_data);
                end else begin
                    e = sb.pop_front();
                    check("sb_bin", 64'({bin_data, bin_index, bin_last}), 64'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [SS-1:0] pd;
        logic [IW-1:0] pi;
        logic          stalled;
        int            c;

        reset_n = 1'b0;
        frame_strobe = 1'b0;
        frame_bitstream = '0;
        flush = 1'b0;
        bin_ready = 1'b0;
        #12;
        check_zero("reset");
        tick();
        reset_n = 1'b1;
        tick();

        // Full-rate stream, exact timing.
        bin_ready = 1'b1;
        frame_bitstream = mkframe(0);
        frame_strobe = 1'b1;
        push_frame(0, 0, BS - 1);
        tick();
        frame_strobe = 1'b0;
        check("t1_first_valid", 64'(bin_valid), 64'd1);
        check("t1_first_busy",  64'(busy), 64'd1);
        check("t1_first_idx",   64'(bin_index), 64'd0);
        check("t1_first_last",  64'(bin_last), 64'd0);
        repeat (BS - 1) tick();
        check("t1_last_idx",  64'(bin_index), 64'(BS - 1));
        check("t1_last_flag", 64'(bin_last), 64'd1);
        tick();
        check("t1_idle_valid", 64'(bin_valid), 64'd0);
        check("t1_idle_busy",  64'(busy), 64'd0);
        check("t1_drain", 64'(sb.size()), 64'd0);

        // Stalled stream, ready pattern 1,0,0 repeating.
        frame_bitstream = mkframe(0);
        frame_strobe = 1'b1;
        push_frame(0, 0, BS - 1);
        tick();
        frame_strobe = 1'b0;
        stalled = 1'b0;
        pd = '0;
        pi = '0;
        c = 0;
        while (busy && c < 300) begin
            if (stalled) begin
                check("t2_stall_data", 64'(bin_data), 64'(pd));
                check("t2_stall_idx",  64'(bin_index), 64'(pi));
            end
            bin_ready = (c % 3 == 0);
            stalled = bin_valid && !bin_ready;
            pd = bin_data;
            pi = bin_index;
            tick();
            c++;
        end
        bin_ready = 1'b1;
        wait_idle("t2");

        // Mid-stream strobes are dropped and counted.
        frame_bitstream = mkframe(0);
        frame_strobe = 1'b1;
        push_frame(0, 0, BS - 1);
        tick();
        frame_strobe = 1'b0;
        c = 0;
        while (busy && c < 100) begin
            if (bin_index == 5 || bin_index == 10 || bin_index == 20) begin
                frame_strobe = 1'b1;
                frame_bitstream = mkframe(2);
            end else begin
                frame_strobe = 1'b0;
            end
            tick();
            c++;
        end
        frame_strobe = 1'b0;
        check("t3_drop3", 64'(drop_count), 64'd3);
        check("t3_drain", 64'(sb.size()), 64'd0);

        bin_ready = 1'b0;
        frame_bitstream = mkframe(0);
        frame_strobe = 1'b1;
        push_frame(0, 0, BS - 1);
        tick();
        frame_bitstream = mkframe(2);
        repeat (300) tick();
        frame_strobe = 1'b0;
        check("t3_drop_sat", 64'(drop_count), 64'd255);
        check("t3_sat_idx",  64'(bin_index), 64'd0);
        bin_ready = 1'b1;
        wait_idle("t3");

        // Back-to-back frames via strobe on the last handshake.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        check("t4_drop_cleared", 64'(drop_count), 64'd0);
        frame_bitstream = mkframe(0);
        frame_strobe = 1'b1;
        push_frame(0, 0, BS - 1);
        push_frame(1, 0, BS - 1);
        tick();
        frame_strobe = 1'b0;
        wait_index(BS - 1);
        frame_strobe = 1'b1;
        frame_bitstream = mkframe(1);
        tick();
        frame_strobe = 1'b0;
        check("t4_idx",  64'(bin_index), 64'd0);
        check("t4_data", 64'(bin_data), 64'(binval(1, 0)));
        check("t4_busy", 64'(busy), 64'd1);
        check("t4_drop", 64'(drop_count), 64'd0);
        wait_idle("t4");

        // Flush at index 7, with a coincident strobe that must be ignored.
        frame_bitstream = mkframe(0);
        frame_strobe = 1'b1;
        push_frame(0, 0, 6);
        tick();
        frame_strobe = 1'b0;
        wait_index(7);
        bin_ready = 1'b0;
        flush = 1'b1;
        frame_strobe = 1'b1;
        frame_bitstream = mkframe(1);
        tick();
        flush = 1'b0;
        frame_strobe = 1'b0;
        bin_ready = 1'b1;
        check("t5_valid", 64'(bin_valid), 64'd0);
        check("t5_busy",  64'(busy), 64'd0);
        check("t5_idx",   64'(bin_index), 64'd0);
        check("t5_drop",  64'(drop_count), 64'd0);
        check("t5_drain", 64'(sb.size()), 64'd0);
        frame_bitstream = mkframe(2);
        frame_strobe = 1'b1;
        push_frame(2, 0, BS - 1);
        tick();
        frame_strobe = 1'b0;
        check("t5_new_idx",  64'(bin_index), 64'd0);
        check("t5_new_data", 64'(bin_data), 64'(binval(2, 0)));
        wait_idle("t5");

        // Asynchronous reset at index 12.
        frame_bitstream = mkframe(0);
        frame_strobe = 1'b1;
        push_frame(0, 0, BS - 1);
        tick();
        frame_strobe = 1'b0;
        wait_index(3);
        frame_strobe = 1'b1;
        tick();
        frame_strobe = 1'b0;
        wait_index(12);
        check("t6_drop_pre", 64'(drop_count), 64'd1);
        reset_n = 1'b0;
        #1;
        check_zero("t6_rst");
        sb.delete();
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        check("t6_post_valid", 64'(bin_valid), 64'd0);
        frame_bitstream = mkframe(2);
        frame_strobe = 1'b1;
        push_frame(2, 0, BS - 1);
        tick();
        frame_strobe = 1'b0;
        check("t6_new_idx",  64'(bin_index), 64'd0);
        check("t6_new_data", 64'(bin_data), 64'(binval(2, 0)));
        wait_idle("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_bin_streamer.md
FFT_BIN_STREAMER -- requirements
Module: fft_bin_streamer

Interface
REQ-001 The block SHALL have parameter sample_size, default 32, giving the width of one signed FFT bin.
REQ-002 The block SHALL have parameter buffer_size, default 32, giving the number of bins per frame (power of two, >= 2).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (all state on rising edge); reset_n input 1 (async assert, active-low).
REQ-004 frame_strobe  input  1  single-cycle pulse: frame_bitstream holds a complete FFT output frame.
REQ-005 frame_bitstream  input  sample_size*buffer_size  packed signed bins, bin k at [k*sample_size +: sample_size].
REQ-006 flush  input  1  synchronous abort of the frame in progress.
REQ-007 bin_valid  output  1  bin_data/bin_index/bin_last valid.
REQ-008 bin_ready  input  1  downstream accepts the current bin.
REQ-009 bin_data  output  sample_size  signed bin value.
REQ-010 bin_index  output  $clog2(buffer_size)  index of the current bin.
REQ-011 bin_last  output  1  high with bin_valid when bin_index == buffer_size-1.
REQ-012 busy  output  1  high while a frame is held (STREAM state).
REQ-013 drop_count  output  8  number of frames dropped; saturates at 255.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and STREAM.
REQ-015 In IDLE, frame_strobe=1 SHALL capture frame_bitstream into an internal frame register, set index to 0, and enter STREAM on the next edge.
REQ-016 In STREAM, bin_valid and busy SHALL be 1; bin_data SHALL equal bits [index*sample_size +: sample_size] of the captured register.
REQ-017 First bin_valid SHALL appear exactly one cycle after the accepting frame_strobe cycle.
REQ-018 A handshake SHALL occur on a cycle with bin_valid=1 and bin_ready=1; only then SHALL index advance by 1.
REQ-019 While bin_valid=1 and bin_ready=0, bin_data, bin_index and bin_last SHALL remain stable.
REQ-020 A handshake with index == buffer_size-1 SHALL return to IDLE and reset index to 0, unless REQ-022 applies.
REQ-021 frame_strobe in STREAM, other than on the last-bin handshake cycle, SHALL be ignored (captured register unchanged) and SHALL increment drop_count by 1, saturating at 255.
REQ-022 frame_strobe on the same cycle as the last-bin handshake SHALL be accepted: capture the new frame, stay in STREAM with index 0, no drop counted (back-to-back frames, no bubble).
REQ-023 flush=1 SHALL force IDLE and index 0 on the next edge, overriding any handshake; frame_strobe coincident with flush SHALL be ignored and not counted.
REQ-024 In IDLE, bin_valid, bin_last and busy SHALL be 0; bin_index SHALL be 0.
REQ-025 bin_data SHALL be passed through unmodified (no scaling, no sign change).

Reset
REQ-026 On reset_n=0, the block SHALL immediately enter IDLE with index 0, frame register 0, drop_count 0, bin_valid 0, bin_last 0, busy 0, bin_data 0.
REQ-027 Reset during STREAM SHALL discard the held frame; after release, the next frame_strobe SHALL start at bin 0.
REQ-028 No output SHALL depend on state from before the most recent reset assertion.

Verification
REQ-029 Frame bin k = 10*k - 100, bin_ready=1 throughout -> 32 consecutive bins, values -100..210, indices 0..31, bin_last only on index 31, IDLE on the next cycle.
REQ-030 Same frame, bin_ready toggling 1,0,0,1,... -> bin_data/bin_index stable in every stall cycle, all 32 bins delivered in order, no duplicate or missing bin.
REQ-031 Three frame_strobes mid-stream (indices 5, 10, 20) -> drop_count=3, the streamed frame unchanged; 300 mid-stream strobes -> drop_count=255.
REQ-032 frame_strobe on the last-bin handshake cycle with a new frame (all bins = -1) -> next cycle bin_index=0, bin_data=-1, busy stays 1, drop_count unchanged.
REQ-033 flush asserted at index 7 -> IDLE next cycle with bin_valid=0; the next strobe starts at bin 0 with the new frame.
REQ-034 reset_n pulsed low at index 12 -> outputs zero asynchronously, drop_count=0, and the next frame streams from bin 0.
